display_update_scheduler: RTL and testbench

// Sequences display refresh for the four-mode measurement display: picks the mode source, runs the

---
 rtl/display_update_scheduler_pkg.sv | 41 ++++
 rtl/display_update_scheduler_if.sv | 15 +
 rtl/display_update_scheduler_blank_gen.sv | 43 ++++
 rtl/display_update_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_display_update_scheduler.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_update_scheduler_pkg.sv
// Shared types and constants for the display update scheduler.
//   mode_t  : display mode selected by the two mode switches
//   state_t : refresh sequencer states
//   DP_*    : decimal-point enable pattern per mode (bit 5 = HEX5 .. bit 0 = HEX0)
//   BLANK_* : fixed blanking patterns used at reset and in switch mode
package display_update_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_HEX  = 2'b00,
        MODE_AVE  = 2'b01,
        MODE_DIST = 2'b10,
        MODE_VOLT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SELECT    = 2'b01,
        WAIT_DONE = 2'b10,
        COMMIT    = 2'b11
    } state_t;

    localparam logic [5:0] DP_HEX      = 6'b00_0000;
    localparam logic [5:0] DP_AVE      = 6'b00_0000;
    localparam logic [5:0] DP_DIST     = 6'b00_0100;
    localparam logic [5:0] DP_VOLT     = 6'b00_1000;

    localparam logic [5:0] BLANK_RESET = 6'b11_1110;
    localparam logic [5:0] BLANK_HEX   = 6'b11_0000;

    function automatic logic [5:0] dp_for_mode(input mode_t m);
        logic [5:0] dp;
        unique case (m)
            MODE_HEX:  dp = DP_HEX;
            MODE_AVE:  dp = DP_AVE;
            MODE_DIST: dp = DP_DIST;
            MODE_VOLT: dp = DP_VOLT;
        endcase
        return dp;
    endfunction

endpackage

// File: rtl/display_update_scheduler_if.sv
// Start/done handshake between the scheduler and the shared binary-to-BCD converter.
//   bcd_start  : one-cycle launch pulse (scheduler -> converter)
//   bcd_bin    : 13-bit binary operand, held stable while waiting (scheduler -> converter)
//   bcd_done   : one-cycle result-valid pulse (converter -> scheduler)
//   bcd_result : four packed BCD digits (converter -> scheduler)
// master = scheduler side, slave = converter side.
interface display_update_scheduler_if;
    logic        bcd_start;
    logic [12:0] bcd_bin;
    logic        bcd_done;
    logic [15:0] bcd_result;

    modport master (output bcd_start, output bcd_bin, input bcd_done, input bcd_result);
    modport slave  (input bcd_start, input bcd_bin, output bcd_done, output bcd_result);
endinterface

// File: rtl/display_update_scheduler_blank_gen.sv
// Combinational digit-blanking pattern for the six seven-segment digits.
//   upper_digits : HEX3..HEX1 nibbles of the value about to be displayed
//                  (HEX0 is never blanked, so its nibble is not needed)
//   mode         : mode the value was produced in
//   blank        : blank enables, bit 5 = HEX5 .. bit 0 = HEX0
// HEX5/HEX4 are always dark. In switch mode the pattern is fixed; otherwise
// leading zeros are blanked from the most significant digit downward, but
// never the digit carrying the decimal point or anything right of it.
module display_update_scheduler_blank_gen
    import display_update_scheduler_pkg::*;
(
    input  logic [11:0] upper_digits,
    input  mode_t       mode,
    output logic [5:0]  blank
);

    // lead_zero[i]: digit i and every digit above it are zero
    logic [3:1] lead_zero;
    // allow[i]: digit i sits left of the decimal point and may be blanked
    logic [3:1] allow;

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_digit
            assign lead_zero[gi] = ~(|upper_digits[11:4*(gi-1)]);
        end
    endgenerate

    always_comb begin
        allow = 3'b111;
        blank = BLANK_HEX;
        unique case (mode)
            MODE_HEX:  allow = 3'b000;
            MODE_AVE:  allow = 3'b111;
            MODE_DIST: allow = 3'b100;   // DP on HEX2
            MODE_VOLT: allow = 3'b000;   // DP on HEX3
        endcase
        if (mode != MODE_HEX) begin
            blank = {2'b11, lead_zero & allow, 1'b0};
        end
    end

endmodule

// File: rtl/display_update_scheduler.sv
// Display refresh sequencer for the four-mode measurement display.
// Picks the source for the current mode, runs the shared binary-to-BCD converter
// for the decimal modes, and commits value, decimal points and blanking to the
// display register unless the display is frozen.
//   clk, reset_n             : clock, asynchronous active-low reset
//   mode                     : 00 switches, 01 ADC average, 10 distance, 11 voltage
//   sw_value/ave_value/
//   distance/voltage         : mode data sources
//   write_enable             : 1 = live update, 0 = freeze display outputs
//   bcd                      : converter handshake (master side)
//   disp_value, DP, Blank    : registered display outputs
//   busy                     : sequencer not idle
//   timeout_err              : sticky converter timeout flag, cleared by mode change
module display_update_scheduler
    import display_update_scheduler_pkg::*;
#(
    parameter int REFRESH_CYCLES = 250,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 mode,
    input  logic [7:0]                 sw_value,
    input  logic [15:0]                ave_value,
    input  logic [12:0]                distance,
    input  logic [12:0]                voltage,
    input  logic                       write_enable,
    display_update_scheduler_if.master bcd,
    output logic [15:0]                disp_value,
    output logic [5:0]                 DP,
    output logic [5:0]                 Blank,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    mode_t             prev_mode_q,   prev_mode_d;
    logic              pending_q,     pending_d;
    logic              stale_q,       stale_d;
    mode_t             tag_mode_q,    tag_mode_d;
    logic [15:0]       result_q,      result_d;
    logic [TO_W-1:0]   to_cnt_q,      to_cnt_d;
    logic              bcd_start_q,   bcd_start_d;
    logic [12:0]       bcd_bin_q,     bcd_bin_d;
    logic [15:0]       disp_value_q,  disp_value_d;
    logic [5:0]        dp_q,          dp_d;
    logic [5:0]        blank_q,       blank_d;
    logic              busy_q,        busy_d;
    logic              timeout_err_q, timeout_err_d;

    mode_t      mode_now;
    logic       mode_change;
    logic       wrap;
    logic       launch;
    logic [5:0] blank_new;

    assign mode_now    = mode_t'(mode);
    assign mode_change = (mode_now != prev_mode_q);
    assign wrap        = (cnt_q == CNT_LAST);
    assign launch      = wrap | mode_change;

    // Blanking is derived from the latched result and the mode it was produced in.
    display_update_scheduler_blank_gen u_blank_gen (
        .upper_digits (result_q[15:4]),
        .mode         (tag_mode_q),
        .blank        (blank_new)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = (wrap || mode_change) ? '0 : cnt_q + 1'b1;
        prev_mode_d   = mode_now;
        // Launches while the sequencer is busy collapse into one pending request.
        pending_d     = pending_q | (launch & (state_q != IDLE));
        // A mode change after the operand was picked invalidates the in-flight result.
        stale_d       = stale_q | (mode_change & (state_q != IDLE));
        tag_mode_d    = tag_mode_q;
        result_d      = result_q;
        to_cnt_d      = to_cnt_q;
        bcd_start_d   = 1'b0;
        bcd_bin_d     = bcd_bin_q;
        disp_value_d  = disp_value_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        timeout_err_d = mode_change ? 1'b0 : timeout_err_q;

        unique case (state_q)
            IDLE: begin
                // Requests that find the display frozen are dropped, not deferred.
                pending_d = 1'b0;
                if ((launch || pending_q) && write_enable) begin
                    state_d = SELECT;
                    stale_d = 1'b0;
                end
            end
            SELECT: begin
                tag_mode_d = mode_now;
                to_cnt_d   = '0;
                unique case (mode_now)
                    MODE_HEX: begin
                        result_d = {8'h00, sw_value};
                        state_d  = COMMIT;
                    end
                    MODE_AVE: begin
                        result_d = ave_value;
                        state_d  = COMMIT;
                    end
                    MODE_DIST: begin
                        bcd_bin_d   = distance;
                        bcd_start_d = 1'b1;
                        state_d     = WAIT_DONE;
                    end
                    MODE_VOLT: begin
                        bcd_bin_d   = voltage;
                        bcd_start_d = 1'b1;
                        state_d     = WAIT_DONE;
                    end
                endcase
            end
            WAIT_DONE: begin
                if (bcd.bcd_done) begin
                    result_d = bcd.bcd_result;
                    state_d  = COMMIT;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                if (write_enable && !stale_q && (tag_mode_q == mode_now)) begin
                    disp_value_d = result_q;
                    dp_d         = dp_for_mode(tag_mode_q);
                    blank_d      = blank_new;
                end
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            prev_mode_q   <= MODE_HEX;
            pending_q     <= 1'b0;
            stale_q       <= 1'b0;
            tag_mode_q    <= MODE_HEX;
            result_q      <= '0;
            to_cnt_q      <= '0;
            bcd_start_q   <= 1'b0;
            bcd_bin_q     <= '0;
            disp_value_q  <= '0;
            dp_q          <= '0;
            blank_q       <= BLANK_RESET;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_mode_q   <= prev_mode_d;
            pending_q     <= pending_d;
            stale_q       <= stale_d;
            tag_mode_q    <= tag_mode_d;
            result_q      <= result_d;
            to_cnt_q      <= to_cnt_d;
            bcd_start_q   <= bcd_start_d;
            bcd_bin_q     <= bcd_bin_d;
            disp_value_q  <= disp_value_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bcd.bcd_start = bcd_start_q;
    assign bcd.bcd_bin   = bcd_bin_q;
    assign disp_value    = disp_value_q;
    assign DP            = dp_q;
    assign Blank         = blank_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_display_update_scheduler.sv
// Self-checking bench for display_update_scheduler with a behavioural
// binary-to-BCD converter and a reference model of what the display must show.
module tb_display_update_scheduler;

    localparam int REFRESH = 250;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [7:0]  sw_value;
    logic [15:0] ave_value;
    logic [12:0] distance;
    logic [12:0] voltage;
    logic        write_enable;
    logic [15:0] disp_value;
    logic [5:0]  DP;
    logic [5:0]  Blank;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    display_update_scheduler_if bif ();

    display_update_scheduler #(
        .REFRESH_CYCLES (REFRESH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode),
        .sw_value     (sw_value),
        .ave_value    (ave_value),
        .distance     (distance),
        .voltage      (voltage),
        .write_enable (write_enable),
        .bcd          (bif),
        .disp_value   (disp_value),
        .DP           (DP),
        .Blank        (Blank),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] exp_value(input logic [1:0] m);
        case (m)
            2'd0:    return {8'h00, sw_value};
            2'd1:    return ave_value;
            2'd2:    return to_bcd(int'(distance));
            default: return to_bcd(int'(voltage));
        endcase
    endfunction

    function automatic logic [5:0] exp_dp(input logic [1:0] m);
        case (m)
            2'd2:    return 6'b00_0100;
            2'd3:    return 6'b00_1000;
            default: return 6'b00_0000;
        endcase
    endfunction

    // Walk digits from HEX3 down: blank zeros until a non-zero digit or the DP digit.
    function automatic logic [5:0] exp_blank(input logic [1:0] m, input logic [15:0] v);
        logic [5:0] r;
        int dp_pos;
        r = 6'b11_0000;
        if (m == 2'd0) return r;
        dp_pos = (m == 2'd2) ? 2 : (m == 2'd3) ? 3 : 0;
        for (int i = 3; i >= 1; i--) begin
            if (i <= dp_pos) break;
            if (v[4*i +: 4] != 4'h0) break;
            r[i] = 1'b1;
        end
        return r;
    endfunction

    // ---------------- converter model ----------------
    int          conv_latency = 5;
    bit          conv_enable  = 1'b1;
    int          conv_cnt     = -1;
    logic [12:0] conv_bin;
    int          start_count  = 0;
    int          double_start = 0;
    bit          prev_start   = 1'b0;

    always @(negedge clk) begin
        bif.bcd_done   = 1'b0;
        bif.bcd_result = 16'($urandom);
        if (!reset_n) begin
            conv_cnt   = -1;
            prev_start = 1'b0;
        end else begin
            if (conv_cnt > 0) conv_cnt--;
            if (conv_cnt == 0) begin
                if (conv_enable) begin
                    bif.bcd_done   = 1'b1;
                    bif.bcd_result = to_bcd(int'(conv_bin));
                end
                conv_cnt = -1;
            end
            if (bif.bcd_start === 1'b1) begin
                start_count++;
                if (prev_start) double_start++;
                conv_bin = bif.bcd_bin;
                conv_cnt = conv_latency;
            end
            prev_start = (bif.bcd_start === 1'b1);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] m);
        reset_n = 1'b0;
        mode    = m;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_display(input logic [15:0] d, input logic [5:0] p, input logic [5:0] b,
                                input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (disp_value === d && DP === p && Blank === b) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int s0, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (start_count > s0) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit hit;
        int s0;
        conv_enable = 1'b0;
        voltage     = 13'd2500;
        apply_reset(2'b11);
        wait_start(start_count, 10, hit);
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL reset_launch: no bcd_start seen, required one within 10 clk"); end
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_before: busy=%b required 1", busy); end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (disp_value !== 16'h0000) begin n_fail++; $display("FAIL reset_disp: got %h required 0000", disp_value); end
        n_checks++;
        if (DP !== 6'b00_0000) begin n_fail++; $display("FAIL reset_dp: got %b required 000000", DP); end
        n_checks++;
        if (Blank !== 6'b11_1110) begin n_fail++; $display("FAIL reset_blank: got %b required 111110", Blank); end
        n_checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b timeout_err=%b required 0 0", busy, timeout_err);
        end
        n_checks++;
        if (bif.bcd_start !== 1'b0 || bif.bcd_bin !== 13'd0) begin
            n_fail++; $display("FAIL reset_bcd: start=%b bin=%0d required 0 0", bif.bcd_start, bif.bcd_bin);
        end
        s0 = start_count;
        repeat (4) tick();
        n_checks++;
        if (start_count !== s0) begin n_fail++; $display("FAIL reset_no_start: %0d starts in reset, required 0", start_count - s0); end
        reset_n = 1'b1;
        conv_enable = 1'b1;
        $display("txn reset: disp=%h DP=%b Blank=%b", disp_value, DP, Blank);
    endtask

    task automatic test_hex();
        bit hit;
        int s0;
        sw_value     = 8'hA5;
        write_enable = 1'b1;
        s0 = start_count;
        apply_reset(2'b00);
        wait_display(16'h00A5, 6'b00_0000, 6'b11_0000, REFRESH + 3, hit);
        n_checks++;
        if (disp_value !== 16'h00A5) begin n_fail++; $display("FAIL hex_disp: got %h required 00a5", disp_value); end
        n_checks++;
        if (DP !== 6'b00_0000) begin n_fail++; $display("FAIL hex_dp: got %b required 000000", DP); end
        n_checks++;
        if (Blank !== 6'b11_0000) begin n_fail++; $display("FAIL hex_blank: got %b required 110000", Blank); end
        n_checks++;
        if (start_count !== s0) begin n_fail++; $display("FAIL hex_no_start: %0d bcd_start pulses, required 0", start_count - s0); end
        $display("txn hex: disp=%h DP=%b Blank=%b hit=%0d", disp_value, DP, Blank, hit);
    endtask

    task automatic test_voltage();
        bit hit;
        int s0;
        conv_latency = 17;
        voltage      = 13'd1234;
        s0 = start_count;
        apply_reset(2'b11);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.bcd_done === 1'b1) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL volt_done: no bcd_done within 40 clk"); end
        n_checks++;
        if (start_count - s0 !== 1) begin n_fail++; $display("FAIL volt_starts: got %0d pulses required 1", start_count - s0); end
        n_checks++;
        if (bif.bcd_bin !== 13'd1234) begin n_fail++; $display("FAIL volt_bin: got %0d required 1234", bif.bcd_bin); end
        tick();
        n_checks++;
        if (disp_value !== 16'h0000) begin n_fail++; $display("FAIL volt_early: got %h one clk after done, required 0000", disp_value); end
        tick();
        n_checks++;
        if (disp_value !== 16'h1234) begin n_fail++; $display("FAIL volt_disp: got %h required 1234", disp_value); end
        n_checks++;
        if (DP !== 6'b00_1000) begin n_fail++; $display("FAIL volt_dp: got %b required 001000", DP); end
        n_checks++;
        if (Blank !== exp_blank(2'd3, 16'h1234)) begin n_fail++; $display("FAIL volt_blank: got %b required 110000", Blank); end
        n_checks++;
        if (double_start !== 0) begin n_fail++; $display("FAIL volt_pulse_width: %0d multi-cycle starts, required 0", double_start); end
        $display("txn voltage: disp=%h DP=%b Blank=%b", disp_value, DP, Blank);
    endtask

    task automatic test_distance_blank();
        bit hit;
        conv_latency = 5;
        distance     = 13'd618;
        apply_reset(2'b10);
        wait_display(16'h0618, 6'b00_0100, 6'b11_1000, 40, hit);
        n_checks++;
        if (disp_value !== 16'h0618) begin n_fail++; $display("FAIL dist_disp: got %h required 0618", disp_value); end
        n_checks++;
        if (Blank !== 6'b11_1000) begin n_fail++; $display("FAIL dist_blank: got %b required 111000", Blank); end
        n_checks++;
        if (DP !== 6'b00_0100) begin n_fail++; $display("FAIL dist_dp: got %b required 000100", DP); end
        $display("txn distance 618: disp=%h DP=%b Blank=%b", disp_value, DP, Blank);
        distance = 13'd0;
        wait_display(16'h0000, 6'b00_0100, 6'b11_1000, REFRESH + 20, hit);
        n_checks++;
        if (disp_value !== 16'h0000) begin n_fail++; $display("FAIL dist0_disp: got %h required 0000", disp_value); end
        n_checks++;
        if (Blank !== 6'b11_1000) begin n_fail++; $display("FAIL dist0_blank: got %b required 111000", Blank); end
        $display("txn distance 0: disp=%h DP=%b Blank=%b", disp_value, DP, Blank);
        ave_value = 16'h0064;
        mode      = 2'b01;
        wait_display(16'h0064, 6'b00_0000, 6'b11_1100, 10, hit);
        n_checks++;
        if (Blank !== 6'b11_1100 || disp_value !== 16'h0064) begin
            n_fail++; $display("FAIL ave_blank: disp=%h Blank=%b required 0064 111100", disp_value, Blank);
        end
        $display("txn average 0x0064: disp=%h DP=%b Blank=%b", disp_value, DP, Blank);
    endtask

    task automatic test_freeze();
        bit hit;
        int viol;
        write_enable = 1'b1;
        sw_value     = 8'hFF;
        apply_reset(2'b00);
        wait_display(16'h00FF, 6'b00_0000, 6'b11_0000, REFRESH + 3, hit);
        n_checks++;
        if (disp_value !== 16'h00FF) begin n_fail++; $display("FAIL freeze_pre: got %h required 00ff", disp_value); end
        write_enable = 1'b0;
        sw_value     = 8'h00;
        for (int p = 0; p < 3; p++) begin
            viol = 0;
            for (int c = 0; c < REFRESH; c++) begin
                if (p == 1 && c == 0) begin mode = 2'b01; ave_value = 16'($urandom); end
                if (p == 2 && c == 0) mode = 2'b00;
                tick();
                if (disp_value !== 16'h00FF || DP !== 6'b00_0000 || Blank !== 6'b11_0000) viol++;
            end
            n_checks++;
            if (viol != 0) begin
                n_fail++; $display("FAIL freeze_hold_p%0d: %0d cycles changed, last disp=%h DP=%b Blank=%b, required 00ff 000000 110000",
                                   p, viol, disp_value, DP, Blank);
            end
        end
        write_enable = 1'b1;
        wait_display(16'h0000, 6'b00_0000, 6'b11_0000, REFRESH + 3, hit);
        n_checks++;
        if (disp_value !== 16'h0000) begin n_fail++; $display("FAIL freeze_release: got %h required 0000", disp_value); end
        $display("txn freeze/release: disp=%h DP=%b Blank=%b", disp_value, DP, Blank);
    endtask

    task automatic test_timeout();
        bit hit;
        int elapsed;
        conv_enable  = 1'b0;
        write_enable = 1'b1;
        voltage      = 13'd100;
        apply_reset(2'b11);
        wait_start(start_count, 10, hit);
        elapsed = 0;
        for (int i = 0; i < TIMEOUT + 16; i++) begin
            tick();
            elapsed++;
            if (timeout_err === 1'b1) break;
        end
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b required 1", timeout_err); end
        n_checks++;
        if (elapsed != TIMEOUT) begin n_fail++; $display("FAIL timeout_delay: got %0d clk required %0d", elapsed, TIMEOUT); end
        n_checks++;
        if (disp_value !== 16'h0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_state: disp=%h busy=%b required 0000 0", disp_value, busy);
        end
        repeat (5) tick();
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
        conv_enable = 1'b1;
        distance    = 13'd42;
        mode        = 2'b10;
        tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b required 0", timeout_err); end
        wait_display(16'h0042, 6'b00_0100, exp_blank(2'd2, 16'h0042), 40, hit);
        n_checks++;
        if (disp_value !== 16'h0042 || Blank !== 6'b11_1000) begin
            n_fail++; $display("FAIL timeout_recover: disp=%h Blank=%b required 0042 111000", disp_value, Blank);
        end
        $display("txn timeout: elapsed=%0d disp=%h", elapsed, disp_value);
    endtask

    task automatic test_mode_change();
        bit hit;
        bit stale_seen;
        int s0;
        conv_enable  = 1'b1;
        conv_latency = 30;
        voltage      = 13'd4321;
        s0 = start_count;
        apply_reset(2'b11);
        wait_start(s0, 10, hit);
        repeat (5) tick();
        distance = 13'd777;
        mode     = 2'b10;
        stale_seen = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (disp_value === 16'h4321) stale_seen = 1'b1;
            if (disp_value === 16'h0777) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (stale_seen) begin n_fail++; $display("FAIL stale_commit: stale voltage 4321 was displayed, required discard"); end
        n_checks++;
        if (disp_value !== 16'h0777) begin n_fail++; $display("FAIL newmode_disp: got %h required 0777", disp_value); end
        n_checks++;
        if (DP !== 6'b00_0100 || Blank !== 6'b11_1000) begin
            n_fail++; $display("FAIL newmode_dpblank: DP=%b Blank=%b required 000100 111000", DP, Blank);
        end
        n_checks++;
        if (start_count - s0 !== 2) begin n_fail++; $display("FAIL newmode_starts: got %0d required 2", start_count - s0); end
        $display("txn mode change: disp=%h DP=%b Blank=%b", disp_value, DP, Blank);
    endtask

    task automatic test_random();
        bit hit;
        logic [1:0]  m;
        logic [15:0] ev;
        logic [5:0]  ed;
        logic [5:0]  eb;
        conv_enable  = 1'b1;
        write_enable = 1'b1;
        apply_reset(2'b00);
        for (int t = 0; t < 12; t++) begin
            m            = 2'($urandom_range(0, 3));
            sw_value     = 8'($urandom);
            ave_value    = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ave_value = ave_value >> (4 * $urandom_range(1, 3));
            distance     = 13'($urandom_range(0, 8191));
            voltage      = 13'($urandom_range(0, 8191));
            conv_latency = $urandom_range(1, 20);
            mode         = m;
            ev = exp_value(m);
            ed = exp_dp(m);
            eb = exp_blank(m, ev);
            wait_display(ev, ed, eb, REFRESH + 60, hit);
            n_checks++;
            if (disp_value !== ev) begin n_fail++; $display("FAIL rand%0d_disp: mode=%0d got %h required %h", t, m, disp_value, ev); end
            n_checks++;
            if (DP !== ed) begin n_fail++; $display("FAIL rand%0d_dp: mode=%0d got %b required %b", t, m, DP, ed); end
            n_checks++;
            if (Blank !== eb) begin n_fail++; $display("FAIL rand%0d_blank: mode=%0d got %b required %b", t, m, Blank, eb); end
            $display("txn rand %0d: mode=%0d disp=%h DP=%b Blank=%b", t, m, disp_value, DP, Blank);
        end
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        mode         = 2'b00;
        sw_value     = 8'h00;
        ave_value    = 16'h0000;
        distance     = 13'd0;
        voltage      = 13'd0;
        write_enable = 1'b1;
        tick();
        test_reset();
        test_hex();
        test_voltage();
        test_distance_blank();
        test_freeze();
        test_timeout();
        test_mode_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
